// File: rtl/bin2bcd_seq_if.sv
// Handshake and data bundle for the sequential binary-to-BCD converter.
// Optional macro BIN2BCD_LZB_EN adds the leading-zero blanking vector.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W = 7,
  parameter int unsigned NDIG  = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic [NDIG*4-1:0]     bcd;
  logic                  ready;
  logic                  done_tick;
`ifdef BIN2BCD_LZB_EN
  logic [NDIG-1:0]       blank;

  modport master (output start, output bin,
                  input bcd, input ready, input done_tick, input blank);
  modport slave  (input start, input bin,
                  output bcd, output ready, output done_tick, output blank);
`else
  modport master (output start, output bin,
                  input bcd, input ready, input done_tick);
  modport slave  (input start, input bin,
                  output bcd, output ready, output done_tick);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, shift-and-add-3, one bit per clock.
// Optional macro BIN2BCD_LZB_EN: registered leading-zero blanking flags.
module bin2bcd_seq #(
  parameter int unsigned BIN_W = 7,
  parameter int unsigned NDIG  = 3
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);
  localparam int unsigned BCD_W = NDIG * 4;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, OP = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_n;
  logic [BCD_W-1:0]   bcd_q, bcd_n, adj;
  logic [BIN_W-1:0]   sreg, sreg_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ready_q, done_q;

  // State and datapath registers; Moore outputs are registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_q   <= '0;
      sreg    <= '0;
      cnt     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      bcd_q   <= bcd_n;
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      ready_q <= (state_n == IDLE);
      done_q  <= (state_n == DONE);
    end
  end

  // Next-state logic with the add-3 digit adjust and the combined shift
  always_comb begin
    state_n = state;
    bcd_n   = bcd_q;
    sreg_n  = sreg;
    cnt_n   = cnt;
    adj     = bcd_q;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (bcd_q[4*k +: 4] > 4'd4) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (bus.start) begin
          sreg_n  = bus.bin;
          bcd_n   = '0;
          cnt_n   = CNT_W'(BIN_W);
          state_n = OP;
        end
      end
      OP: begin
        {bcd_n, sreg_n} = {adj, sreg} << 1;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.bcd       = bcd_q;
  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;

`ifdef BIN2BCD_LZB_EN
  logic [NDIG-1:0] blank_q, blank_c;
  logic            upper_zero;

  // Digit k blanks when it and every higher digit are zero; units never blank
  always_comb begin
    blank_c    = '0;
    upper_zero = 1'b1;
    for (int k = int'(NDIG) - 1; k >= 1; k--) begin
      upper_zero = upper_zero && (bcd_n[4*k +: 4] == 4'd0);
      blank_c[k] = upper_zero;
    end
  end

  // Blank flags update only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= '0;
    end else if (state == OP && state_n == DONE) begin
      blank_q <= blank_c;
    end
  end

  assign bus.blank = blank_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle-level behavioural model plus directed literals.
module tb_bin2bcd_seq;
  localparam int unsigned BIN_W = 7;
  localparam int unsigned NDIG  = 3;
  localparam int          DONE_PHASE = BIN_W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .NDIG(NDIG)) bus ();
  bin2bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Decimal digits of v packed as BCD, units digit lowest
  function automatic logic [NDIG*4-1:0] to_bcd(input int v);
    logic [NDIG*4-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < int'(NDIG); k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [NDIG-1:0] to_blank(input int v);
    logic [NDIG-1:0] r;
    int p;
    r = '0;
    p = 10;
    for (int k = 1; k < int'(NDIG); k++) begin
      r[k] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 = idle, 1..BIN_W = converting, BIN_W+1 = result cycle
  int                phase = 0;
  int                m_val = 0;
  logic [NDIG*4-1:0] exp_bcd = '0;
  logic [NDIG-1:0]   exp_blank = '0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      exp_bcd = '0;
      exp_blank = '0;
    end else if (phase == 0) begin
      if (bus.start) begin
        phase = 1;
        m_val = int'(bus.bin);
      end
    end else if (phase == DONE_PHASE) begin
      phase = 0;
    end else begin
      phase++;
      if (phase == DONE_PHASE) begin
        exp_bcd = to_bcd(m_val);
        exp_blank = to_blank(m_val);
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 32'(bus.ready), 32'(phase == 0));
      check("done_tick", 32'(bus.done_tick), 32'(phase == DONE_PHASE));
      if (phase == 0 || phase == DONE_PHASE) check("bcd", 32'(bus.bcd), 32'(exp_bcd));
`ifdef BIN2BCD_LZB_EN
      check("blank", 32'(bus.blank), 32'(exp_blank));
`endif
    end
  end

  // One conversion; returns negedges from acceptance to done_tick
  task automatic convert(input int v, output int lat);
    bus.start = 1'b1;
    bus.bin = BIN_W'(v);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin = BIN_W'(v ^ 7'h55);
    lat = 1;
    while (bus.done_tick !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 30) check("done_timeout", 32'(lat), 32'd8);
  endtask

  task automatic conv_lit(input string name, input int v, input logic [NDIG*4-1:0] lit);
    int lat;
    convert(v, lat);
    check({name, "_lat"}, 32'(lat), 32'd8);
    check(name, 32'(bus.bcd), 32'(lit));
    @(negedge clk);
  endtask

  initial begin
    int lat, d1, d0, v, cyc, rdy_cnt, pulses;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bin = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed literals
    convert(0, lat);
    check("zero_lat", 32'(lat), 32'd8);
    check("zero_bcd", 32'(bus.bcd), 32'h000);
`ifdef BIN2BCD_LZB_EN
    check("zero_blank", 32'(bus.blank), 32'b110);
`endif
    @(negedge clk);
    conv_lit("v127", 127, 12'h127);
`ifdef BIN2BCD_LZB_EN
    check("v127_blank", 32'(bus.blank), 32'b000);
`endif
    conv_lit("v99", 99, 12'h099);
`ifdef BIN2BCD_LZB_EN
    check("v99_blank", 32'(bus.blank), 32'b100);
`endif
    conv_lit("v10", 10, 12'h010);

    // Sweep; 0..99 arrive as two BCD digits from the upstream converter
    for (int i = 0; i < 128; i++) begin
      if (i < 100) begin
        d1 = i / 10;
        d0 = i % 10;
        v = d1 * 10 + d0;
      end else begin
        v = i;
      end
      convert(v, lat);
      @(negedge clk);
    end

    // Start pulse during conversion is ignored
    bus.start = 1'b1;
    bus.bin = 7'd64;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin = 7'd5;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_ready", 32'(bus.ready), 32'd0);
    lat = 0;
    while (bus.done_tick !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("ign_bcd", 32'(bus.bcd), 32'h064);
    @(negedge clk);

    // Reset in the 4th converting cycle aborts
    bus.start = 1'b1;
    bus.bin = 7'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_done", 32'(bus.done_tick), 32'd0);
    conv_lit("v100", 100, 12'h100);

    // Start held high: period 9, one ready cycle between pulses
    bus.start = 1'b1;
    bus.bin = 7'd42;
    pulses = 0;
    cyc = 0;
    rdy_cnt = 0;
    for (int t = 0; t < 60 && pulses < 4; t++) begin
      @(negedge clk);
      cyc++;
      if (bus.ready === 1'b1) rdy_cnt++;
      if (bus.done_tick === 1'b1) begin
        check("held_bcd", 32'(bus.bcd), 32'h042);
        if (pulses > 0) begin
          check("held_period", 32'(cyc), 32'd9);
          check("held_ready", 32'(rdy_cnt), 32'd1);
        end
        pulses++;
        cyc = 0;
        rdy_cnt = 0;
      end
    end
    check("held_pulses", 32'(pulses), 32'd4);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
